// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words into a gated configuration chain
// Optional readback verify (CRC-16 recirculation) enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 58,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_ok,
  output logic              verify_err,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int BL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
`ifdef CCFF_READBACK_EN
    , VERIFY = 2'd3
`endif
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BL_W-1:0]   bits_left;
  logic [CNT_W-1:0]  bits_acc;
  logic [CNT_W-1:0]  remaining;
  logic [BL_W-1:0]   take;
  logic              head_q;

  // Last word of the load may be partial; only the bits still owed to the chain are taken.
  assign remaining  = CNT_W'(CHAIN_LEN) - bits_acc;
  assign take       = (remaining >= CNT_W'(WORD_W)) ? BL_W'(WORD_W) : remaining[BL_W-1:0];
  assign word_ready = (state == LOAD) && (bits_acc != CNT_W'(CHAIN_LEN)) && (bits_left <= BL_W'(1));
  assign busy       = (state != IDLE);

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_ld;
  logic [15:0] crc_rb;
  logic [15:0] crc_rb_next;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign crc_rb_next = crc_step(crc_rb, ccff_tail);
  // Recirculation is combinational so the chain keeps its contents after VERIFY.
  assign ccff_head   = (state == VERIFY) ? ccff_tail : head_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign verify_ok   = 1'b0;
  assign verify_err  = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state       <= IDLE;
      sreg        <= '0;
      bits_left   <= '0;
      bits_acc    <= '0;
      bit_count   <= '0;
      head_q      <= 1'b0;
      ccff_clk_en <= 1'b0;
      done        <= 1'b0;
`ifdef CCFF_READBACK_EN
      verify_ok   <= 1'b0;
      verify_err  <= 1'b0;
      crc_ld      <= 16'hFFFF;
      crc_rb      <= 16'hFFFF;
`endif
    end else if (abort) begin
      state       <= IDLE;
      sreg        <= '0;
      bits_left   <= '0;
      head_q      <= 1'b0;
      ccff_clk_en <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= LOAD;
            sreg      <= '0;
            bits_left <= '0;
            bits_acc  <= '0;
            bit_count <= '0;
`ifdef CCFF_READBACK_EN
            verify_ok  <= 1'b0;
            verify_err <= 1'b0;
            crc_ld     <= 16'hFFFF;
            crc_rb     <= 16'hFFFF;
`endif
          end
        end
        LOAD: begin
          if (bit_count == CNT_W'(CHAIN_LEN)) begin
            head_q <= 1'b0;
`ifdef CCFF_READBACK_EN
            state       <= VERIFY;
            ccff_clk_en <= 1'b1;
            bit_count   <= '0;
`else
            state       <= DONE;
            ccff_clk_en <= 1'b0;
            done        <= 1'b1;
`endif
          end else begin
            if (bits_left != '0) begin
              head_q      <= sreg[0];
              ccff_clk_en <= 1'b1;
              sreg        <= sreg >> 1;
              bits_left   <= bits_left - BL_W'(1);
              bit_count   <= bit_count + CNT_W'(1);
`ifdef CCFF_READBACK_EN
              crc_ld      <= crc_step(crc_ld, sreg[0]);
`endif
            end else begin
              head_q      <= 1'b0;
              ccff_clk_en <= 1'b0;
            end
            // An accept overrides the shift update so the last old bit and the new word chain seamlessly.
            if (word_valid && word_ready) begin
              sreg      <= word_data;
              bits_left <= take;
              bits_acc  <= bits_acc + CNT_W'(take);
            end
          end
        end
`ifdef CCFF_READBACK_EN
        VERIFY: begin
          crc_rb    <= crc_rb_next;
          bit_count <= bit_count + CNT_W'(1);
          if (bit_count == CNT_W'(CHAIN_LEN - 1)) begin
            state       <= DONE;
            ccff_clk_en <= 1'b0;
            done        <= 1'b1;
            verify_ok   <= (crc_rb_next == crc_ld);
            verify_err  <= (crc_rb_next != crc_ld);
          end
        end
`endif
        DONE: begin
          done        <= 1'b0;
          ccff_clk_en <= 1'b0;
          head_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader with a 58-flop model chain
// Readback tests run only when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 58;
`ifdef CCFF_READBACK_EN
  localparam int VER = 58;
`else
  localparam int VER = 0;
`endif

  logic        prog_clk = 1'b0;
  logic        pReset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        word_valid = 1'b0;
  logic [7:0]  word_data = '0;
  logic        word_ready;
  logic        ccff_head;
  logic        ccff_clk_en;
  logic        ccff_tail;
  logic        busy;
  logic        done;
  logic        verify_ok;
  logic        verify_err;
  logic [15:0] bit_count;

  logic [57:0] chain = '0;
  logic        stuck17 = 1'b0;
  logic [57:0] stream;
  logic [57:0] exp_chain;
  logic [57:0] hist;
  logic [7:0]  words [8];
  int          en_cnt, run, max_run, done_cnt, widx;
  int          n_chk = 0;
  int          n_err = 0;

  ccff_chain_loader dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .abort       (abort),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .ccff_head   (ccff_head),
    .ccff_clk_en (ccff_clk_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .verify_ok   (verify_ok),
    .verify_err  (verify_err),
    .bit_count   (bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  // chain[0] is the head-end flop, chain[57] drives ccff_tail
  always @(posedge prog_clk) begin
    logic [57:0] nxt;
    nxt = chain;
    if (ccff_clk_en) nxt = {chain[56:0], ccff_head};
    if (stuck17) nxt[17] = 1'b0;
    chain <= nxt;
  end
  assign ccff_tail = chain[57];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_load(input int gap_en, input int abort_bc, input int rst_bc);
    int   cyc, gap_left, post, abort_at;
    logic stop, aborted;
    en_cnt = 0; run = 0; max_run = 0; done_cnt = 0; hist = '0; widx = 0;
    gap_left = gap_en ? 3 : 0;
    post = -1; stop = 1'b0; cyc = 0; abort_at = abort_bc; aborted = 1'b0;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    while (!stop) begin
      if (ccff_clk_en) begin
        if (en_cnt < CHAIN_LEN) hist[en_cnt] = ccff_head;
        en_cnt++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (done) begin
        done_cnt++;
        if (post < 0) post = 0;
      end
      if (aborted && post == 1) begin
        chk("abort_idle", busy, 0);
        chk("abort_clk_en", ccff_clk_en, 0);
      end
      if (abort_at >= 0 && busy && bit_count == 16'(abort_at)) begin
        abort = 1'b1; aborted = 1'b1; post = 0; abort_at = -1;
      end
      if (rst_bc >= 0 && bit_count == 16'(rst_bc)) begin
        pReset = 1'b1;
        #1;
        chk("rst_clk_en", ccff_clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_ready", word_ready, 0);
        chk("rst_head", ccff_head, 0);
        stop = 1'b1;
      end
      if (gap_left > 0 && widx == 3) begin
        word_valid = 1'b0;
        if (word_ready) gap_left--;
      end else if (widx < 8 && !aborted) begin
        word_valid = 1'b1;
        word_data  = words[widx];
        if (word_ready) widx++;
      end else begin
        word_valid = 1'b0;
      end
      if (post >= 0) post++;
      if (post > 10 || cyc > 600) stop = 1'b1;
      if (!stop) begin
        @(negedge prog_clk);
        abort = 1'b0;
      end
      cyc++;
    end
    word_valid = 1'b0;
    abort = 1'b0;
    chk("timeout", (cyc > 600) ? 1 : 0, 0);
    if (pReset) begin
      @(negedge prog_clk);
      pReset = 1'b0;
    end
  endtask

  initial begin
    words = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'h81, 8'h02};
    for (int k = 0; k < CHAIN_LEN; k++) begin
      stream[k] = words[k / 8][k % 8];
      exp_chain[CHAIN_LEN - 1 - k] = stream[k];
    end

    repeat (2) @(negedge prog_clk);
    chk("reset_clk_en", ccff_clk_en, 0);
    chk("reset_head", ccff_head, 0);
    pReset = 1'b0;
    @(negedge prog_clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", word_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_bit_count", bit_count, 0);
    chk("reset_verify_ok", verify_ok, 0);
    chk("reset_verify_err", verify_err, 0);

    // T1: back-to-back words
    run_load(0, -1, -1);
    chk("t1_en_cnt", en_cnt, CHAIN_LEN + VER);
    chk("t1_max_run", max_run, CHAIN_LEN + VER);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_head_bits", hist, stream);
    chk("t1_chain", chain, exp_chain);
    chk("t1_words", widx, 8);
    chk("t1_ready_after", word_ready, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_bit_count", bit_count, CHAIN_LEN);

    // T2: 3-cycle bubble before word 3
    chain = '0;
    run_load(1, -1, -1);
    chk("t2_en_cnt", en_cnt, CHAIN_LEN + VER);
    chk("t2_max_run", max_run, 34 + VER);
    chk("t2_head_bits", hist, stream);
    chk("t2_chain", chain, exp_chain);
    chk("t2_done_cnt", done_cnt, 1);

    // T3: abort at bit 20, then a clean load
    chain = '0;
    run_load(0, 20, -1);
    chk("t3_en_cnt", en_cnt, 20);
    chk("t3_done_cnt", done_cnt, 0);
    chk("t3_bit_count_hold", bit_count, 20);
    chain = '0;
    run_load(0, -1, -1);
    chk("t3_reload_chain", chain, exp_chain);
    chk("t3_reload_done", done_cnt, 1);

    // T4: reset at bit 30, then a clean load
    chain = '0;
    run_load(0, -1, 30);
    chain = '0;
    run_load(0, -1, -1);
    chk("t4_reload_chain", chain, exp_chain);
    chk("t4_reload_en_cnt", en_cnt, CHAIN_LEN + VER);

`ifdef CCFF_READBACK_EN
    // T5: clean verify leaves the chain intact
    chain = '0;
    run_load(0, -1, -1);
    chk("t5_verify_ok", verify_ok, 1);
    chk("t5_verify_err", verify_err, 0);
    chk("t5_chain", chain, exp_chain);

    // T6: flop 17 holds a loaded 1 but is stuck at 0
    chain = '0;
    stuck17 = 1'b1;
    run_load(0, -1, -1);
    stuck17 = 1'b0;
    chk("t6_verify_ok", verify_ok, 0);
    chk("t6_verify_err", verify_err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
